// File: rtl/sort_loader.sv
// sort_loader: serial-to-parallel front end for the six-input sorter.
// Collects six WIDTH-bit words (valid/ready) into slots a..f, then holds
// the frame with out_valid until out_ready releases it.
// Optional: define SORT_LOADER_FLUSH_EN to add a flush input that pads the
// unfilled slots with all-ones and completes a partial frame early.

module sort_loader_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);
  // One frame slot: cleared on reset, loaded on write, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (wr) q <= din;
  end
endmodule

module sort_loader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SORT_LOADER_FLUSH_EN
  input  logic             flush,
`endif
  output logic [2:0]       count
);
  localparam int NUM_SLOTS = 6;

  typedef enum logic {FILL, FULL} state_t;

  state_t state, state_nxt;
  logic [2:0] count_nxt;
  logic       accept;
  logic       flush_go;

  logic [NUM_SLOTS-1:0]            wr_en;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] wr_data;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] slot_q;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == FULL);
  assign accept    = in_valid && in_ready;

`ifdef SORT_LOADER_FLUSH_EN
  // Flush only counts on a started frame; an empty frame or a held one ignores it.
  assign flush_go = flush && (state == FILL) && (count != 3'd0);
`else
  assign flush_go = 1'b0;
`endif

  // State and word-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      count <= 3'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next state: fill until the sixth word (or flush), hold until released.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      FILL: begin
        if (accept) count_nxt = count + 3'd1;
        if (flush_go) count_nxt = 3'd6;
        if ((accept && count == 3'd5) || flush_go) state_nxt = FULL;
      end
      FULL: begin
        if (out_ready) begin
          state_nxt = FILL;
          count_nxt = 3'd0;
        end
      end
      default: begin
        state_nxt = FILL;
        count_nxt = 3'd0;
      end
    endcase
  end

  // Slot write decode: the accepted word lands in slot[count]; on flush every
  // slot past the accepted word gets the all-ones pad so it sorts last.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = in_data;
      if (accept && count == 3'(i)) begin
        wr_en[i] = 1'b1;
      end else if (flush_go && 3'(i) >= count) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = '1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sort_loader_slot #(.WIDTH(WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .wr  (wr_en[g]),
      .din (wr_data[g]),
      .q   (slot_q[g])
    );
  end

  assign a = slot_q[0];
  assign b = slot_q[1];
  assign c = slot_q[2];
  assign d = slot_q[3];
  assign e = slot_q[4];
  assign f = slot_q[5];
endmodule

// File: doc/sort_loader.md
Name: sort_loader

Overview:
- Serial-to-parallel front end for the six-input combinational sorter.
- Accepts one WIDTH-bit word per valid/ready handshake and fills slots a..f in arrival order.
- Once all six slots are filled, holds the frame and presents it in parallel on a..f with out_valid, so the sorter sees a stable input set.
- Releases the frame on out_ready, then starts collecting the next frame.

Parameters:
- WIDTH, 32, bit width of each data word and of each of a..f.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  incoming word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept a word this cycle.
- a  output  WIDTH  slot 0 (first word of frame).
- b  output  WIDTH  slot 1.
- c  output  WIDTH  slot 2.
- d  output  WIDTH  slot 3.
- e  output  WIDTH  slot 4.
- f  output  WIDTH  slot 5 (last word of frame).
- out_valid  output  1  a..f hold a complete frame.
- out_ready  input  1  downstream has consumed the frame.
- count  output  3  number of words collected in the current frame, 0..6.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=FILL, count=0, a..f=0, out_valid=0, in_ready=1 in the cycle after reset is released. rst has priority over every other input.
- States: FILL and FULL, registered. Outputs in_ready=(state==FILL) and out_valid=(state==FULL), both decoded from registered state only; no combinational path from inputs.
- Input accept: a word is accepted when in_valid&&in_ready at the clock edge.
- FILL:
  - On accept, in_data is written to slot[count] (0→a … 5→f) and count increments.
  - No accept: slots and count hold.
  - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
- FILL→FULL: on the accept that makes count=6. out_valid=1 the next cycle, which is 1 cycle latency after the 6th handshake.
- FULL:
  - in_ready=0; in_valid is ignored and no slot changes.
  - a..f stay stable until released.
  - out_ready=1 at an edge → state=FILL, count=0 next cycle.
  - a..f are NOT cleared and keep the old frame until overwritten slot-by-slot.
- Minimum frame period: 7 cycles (6 accepts + 1 release cycle).
- out_ready while in FILL: ignored.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values.
- count never exceeds 6 and never wraps. Slot index is count[2:0], valid only for 0..5 while in FILL.
- Arithmetic: none on data. Data is copied bit-exact, with no sign handling.

Optional Feature:
- Macro: SORT_LOADER_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - In FILL with count>0, flush=1 at an edge fills every unwritten slot (index ≥ count) with all-ones PAD, sets count=6, and enters FULL. PAD is the maximum value, so pad words sort to the tail.
  - If flush and an accept happen in the same cycle, the word is written first, then the remaining slots are padded.
  - flush with count=0, or in FULL, is ignored.
- Not defined: no flush port exists, and frames complete only after 6 accepts.

Test Plan:
- Reset with rst=1 for 2 cycles → a..f=0, count=0, out_valid=0, in_ready=1.
- Send 60,50,40,30,20,10 back-to-back → a=60 … f=10, count=6, out_valid=1 exactly 1 cycle after the 6th accept, in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 with data 99 → a..f unchanged, no accept. Then out_ready=1 → next cycle count=0, in_ready=1, a still 60.
- Gapped input: 10,_,20,_,_,30,40,50,60 (gaps are in_valid=0) → frame a..f=10..60, with out_valid rising 1 cycle after the word 60.
- Reset mid-frame after 3 words (1,2,3) → a..f=0, count=0. A new frame 7..12 then loads correctly.
- With SORT_LOADER_FLUSH_EN defined: send 5,6 then flush=1 → a=5, b=6, c..f=32'hFFFFFFFF, out_valid=1 the next cycle.
